// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register and ALU operand-select stage.
//            Captures the decoded instruction, detects load-use hazards
//            (inserting a bubble), bypasses MEM/WB write-back at capture,
//            and forwards EX/MEM and MEM/WB results onto the ALU operands.
// Ports    : clk, reset (async, active-low), flush
//            id_*       - decoded instruction fields from ID
//            ex_mem_*   - EX/MEM destination/result for forwarding
//            mem_wb_*   - MEM/WB destination/write-back value
//            stall      - hold PC and IF/ID (combinational)
//            ex_valid, ALUOperation, A, B, shamt - ALU side
//            ex_StoreData, ex_WriteReg, ex_RegWrite/MemRead/MemWrite - to EX/MEM
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [DATA_WIDTH-1:0]     id_ReadData1,
  input  logic [DATA_WIDTH-1:0]     id_ReadData2,
  input  logic [DATA_WIDTH-1:0]     id_Immediate,
  input  logic [4:0]                id_shamt,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic [REG_ADDR_WIDTH-1:0] id_WriteReg,
  input  logic [3:0]                id_ALUOperation,
  input  logic                      id_ALUSrc,
  input  logic                      id_RegWrite,
  input  logic                      id_MemRead,
  input  logic                      id_MemWrite,
  input  logic                      ex_mem_RegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] ex_mem_WriteReg,
  input  logic [DATA_WIDTH-1:0]     ex_mem_ALUResult,
  input  logic                      mem_wb_RegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] mem_wb_WriteReg,
  input  logic [DATA_WIDTH-1:0]     mem_wb_WriteData,
  output logic                      stall,
  output logic                      ex_valid,
  output logic [3:0]                ALUOperation,
  output logic [DATA_WIDTH-1:0]     A,
  output logic [DATA_WIDTH-1:0]     B,
  output logic [4:0]                shamt,
  output logic [DATA_WIDTH-1:0]     ex_StoreData,
  output logic [REG_ADDR_WIDTH-1:0] ex_WriteReg,
  output logic                      ex_RegWrite,
  output logic                      ex_MemRead,
  output logic                      ex_MemWrite
);

  // Registered copies that are not directly visible as outputs
  logic [REG_ADDR_WIDTH-1:0] ex_rs;
  logic [REG_ADDR_WIDTH-1:0] ex_rt;
  logic [DATA_WIDTH-1:0]     ex_ReadData1;
  logic [DATA_WIDTH-1:0]     ex_ReadData2;
  logic [DATA_WIDTH-1:0]     ex_Immediate;
  logic                      ex_ALUSrc;

  logic                      uses_rt;
  logic [DATA_WIDTH-1:0]     capture_rd1;
  logic [DATA_WIDTH-1:0]     capture_rd2;
  logic [DATA_WIDTH-1:0]     fwd_rs;
  logic [DATA_WIDTH-1:0]     fwd_rt;

  // rt is a real source for R-type ops and for stores (store data)
  assign uses_rt = !id_ALUSrc | id_MemWrite;

  // Load in EX whose destination is needed by the instruction in ID
  assign stall = id_valid & ex_valid & ex_MemRead & (ex_WriteReg != '0) &
                 ((ex_WriteReg == id_rs) | (uses_rt & (ex_WriteReg == id_rt)));

  // The register file is written at the end of WB, so a value being written
  // back this cycle must be taken over the stale register-file read.
  always_comb begin
    capture_rd1 = id_ReadData1;
    capture_rd2 = id_ReadData2;
    if (mem_wb_RegWrite && (mem_wb_WriteReg != '0) && (mem_wb_WriteReg == id_rs))
      capture_rd1 = mem_wb_WriteData;
    if (mem_wb_RegWrite && (mem_wb_WriteReg != '0) && (mem_wb_WriteReg == id_rt))
      capture_rd2 = mem_wb_WriteData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid     <= 1'b0;
      ALUOperation <= '0;
      shamt        <= '0;
      ex_WriteReg  <= '0;
      ex_RegWrite  <= 1'b0;
      ex_MemRead   <= 1'b0;
      ex_MemWrite  <= 1'b0;
      ex_ALUSrc    <= 1'b0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_ReadData1 <= '0;
      ex_ReadData2 <= '0;
      ex_Immediate <= '0;
    end else if (flush || stall) begin
      // Bubble: IF/ID holds under stall, so the instruction is re-presented
      ex_valid     <= 1'b0;
      ALUOperation <= '0;
      shamt        <= '0;
      ex_WriteReg  <= '0;
      ex_RegWrite  <= 1'b0;
      ex_MemRead   <= 1'b0;
      ex_MemWrite  <= 1'b0;
      ex_ALUSrc    <= 1'b0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_ReadData1 <= '0;
      ex_ReadData2 <= '0;
      ex_Immediate <= '0;
    end else begin
      ex_valid     <= id_valid;
      ALUOperation <= id_ALUOperation;
      shamt        <= id_shamt;
      ex_WriteReg  <= id_WriteReg;
      ex_RegWrite  <= id_valid & id_RegWrite;
      ex_MemRead   <= id_valid & id_MemRead;
      ex_MemWrite  <= id_valid & id_MemWrite;
      ex_ALUSrc    <= id_ALUSrc;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_ReadData1 <= capture_rd1;
      ex_ReadData2 <= capture_rd2;
      ex_Immediate <= id_Immediate;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB; $0 never forwards
  always_comb begin
    fwd_rs = ex_ReadData1;
    fwd_rt = ex_ReadData2;
    if (ex_mem_RegWrite && (ex_mem_WriteReg != '0) && (ex_mem_WriteReg == ex_rs))
      fwd_rs = ex_mem_ALUResult;
    else if (mem_wb_RegWrite && (mem_wb_WriteReg != '0) && (mem_wb_WriteReg == ex_rs))
      fwd_rs = mem_wb_WriteData;
    if (ex_mem_RegWrite && (ex_mem_WriteReg != '0) && (ex_mem_WriteReg == ex_rt))
      fwd_rt = ex_mem_ALUResult;
    else if (mem_wb_RegWrite && (mem_wb_WriteReg != '0) && (mem_wb_WriteReg == ex_rt))
      fwd_rt = mem_wb_WriteData;
  end

  assign A            = fwd_rs;
  assign B            = ex_ALUSrc ? ex_Immediate : fwd_rt;
  assign ex_StoreData = fwd_rt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Self-checking bench for id_ex_stage. Each cycle the instruction
//            driven into ID is turned into an expected EX entry and queued;
//            one cycle later it is popped and the DUT's EX outputs, with the
//            forwarding inputs present in that cycle, are compared against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_ReadData1, id_ReadData2, id_Immediate;
  logic [4:0]  id_shamt, id_rs, id_rt, id_WriteReg;
  logic [3:0]  id_ALUOperation;
  logic        id_ALUSrc, id_RegWrite, id_MemRead, id_MemWrite;
  logic        ex_mem_RegWrite;
  logic [4:0]  ex_mem_WriteReg;
  logic [31:0] ex_mem_ALUResult;
  logic        mem_wb_RegWrite;
  logic [4:0]  mem_wb_WriteReg;
  logic [31:0] mem_wb_WriteData;
  logic        stall, ex_valid;
  logic [3:0]  ALUOperation;
  logic [31:0] A, B, ex_StoreData;
  logic [4:0]  shamt, ex_WriteReg;
  logic        ex_RegWrite, ex_MemRead, ex_MemWrite;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [4:0]  sh, wr, rs, rt;
    logic        rw, mr, mw, src;
    logic [31:0] d1, d2, imm;
  } ex_t;

  ex_t sb[$];

  id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
    .id_ReadData1(id_ReadData1), .id_ReadData2(id_ReadData2),
    .id_Immediate(id_Immediate), .id_shamt(id_shamt), .id_rs(id_rs),
    .id_rt(id_rt), .id_WriteReg(id_WriteReg), .id_ALUOperation(id_ALUOperation),
    .id_ALUSrc(id_ALUSrc), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
    .id_MemWrite(id_MemWrite), .ex_mem_RegWrite(ex_mem_RegWrite),
    .ex_mem_WriteReg(ex_mem_WriteReg), .ex_mem_ALUResult(ex_mem_ALUResult),
    .mem_wb_RegWrite(mem_wb_RegWrite), .mem_wb_WriteReg(mem_wb_WriteReg),
    .mem_wb_WriteData(mem_wb_WriteData), .stall(stall), .ex_valid(ex_valid),
    .ALUOperation(ALUOperation), .A(A), .B(B), .shamt(shamt),
    .ex_StoreData(ex_StoreData), .ex_WriteReg(ex_WriteReg),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Value an EX operand should see for a given source register
  function automatic logic [31:0] fwd(input logic [4:0] s, input logic [31:0] raw);
    if (ex_mem_RegWrite && ex_mem_WriteReg != 5'd0 && ex_mem_WriteReg == s)
      return ex_mem_ALUResult;
    if (mem_wb_RegWrite && mem_wb_WriteReg != 5'd0 && mem_wb_WriteReg == s)
      return mem_wb_WriteData;
    return raw;
  endfunction

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] wr, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [4:0] sh, input logic [3:0] op,
                        input logic src, input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rs = rs; id_rt = rt; id_WriteReg = wr;
    id_ReadData1 = d1; id_ReadData2 = d2; id_Immediate = imm; id_shamt = sh;
    id_ALUOperation = op; id_ALUSrc = src; id_RegWrite = rw; id_MemRead = mr;
    id_MemWrite = mw;
  endtask

  task automatic set_fwd(input logic emrw, input logic [4:0] emwr, input logic [31:0] emres,
                         input logic mwrw, input logic [4:0] mwwr, input logic [31:0] mwdat);
    ex_mem_RegWrite = emrw; ex_mem_WriteReg = emwr; ex_mem_ALUResult = emres;
    mem_wb_RegWrite = mwrw; mem_wb_WriteReg = mwwr; mem_wb_WriteData = mwdat;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    flush = 1'b0;
  endtask

  // Compare the EX entry in flight, queue the one ID is presenting, advance a cycle.
  task automatic tick();
    ex_t e, n;
    logic st;
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      e = '{default: 0};
    end else begin
      e = sb.pop_front();
    end
    if (!reset) e = '{default: 0};
    st = id_valid && e.v && e.mr && e.wr != 5'd0 &&
         (e.wr == id_rs || ((!id_ALUSrc || id_MemWrite) && e.wr == id_rt));
    check("stall", stall, st);
    check("ex_valid", ex_valid, e.v);
    check("ALUOperation", ALUOperation, e.op);
    check("shamt", shamt, e.sh);
    check("ex_WriteReg", ex_WriteReg, e.wr);
    check("ex_RegWrite", ex_RegWrite, e.rw);
    check("ex_MemRead", ex_MemRead, e.mr);
    check("ex_MemWrite", ex_MemWrite, e.mw);
    check("A", A, fwd(e.rs, e.d1));
    check("B", B, e.src ? e.imm : fwd(e.rt, e.d2));
    check("ex_StoreData", ex_StoreData, fwd(e.rt, e.d2));
    n = '{default: 0};
    if (reset && !flush && !st) begin
      n.v   = id_valid;
      n.op  = id_ALUOperation;
      n.sh  = id_shamt;
      n.wr  = id_WriteReg;
      n.rs  = id_rs;
      n.rt  = id_rt;
      n.src = id_ALUSrc;
      n.imm = id_Immediate;
      n.rw  = id_valid & id_RegWrite;
      n.mr  = id_valid & id_MemRead;
      n.mw  = id_valid & id_MemWrite;
      n.d1  = (mem_wb_RegWrite && mem_wb_WriteReg != 5'd0 && mem_wb_WriteReg == id_rs)
              ? mem_wb_WriteData : id_ReadData1;
      n.d2  = (mem_wb_RegWrite && mem_wb_WriteReg != 5'd0 && mem_wb_WriteReg == id_rt)
              ? mem_wb_WriteData : id_ReadData2;
    end
    sb.push_back(n);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    sb.push_back('{default: 0});
    reset = 1'b0;
    idle();

    // 1. Reset held with random inputs, then released with ID idle
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
             5'($urandom), 4'($urandom), 1'($urandom), 1'b1, 1'b1, 1'($urandom));
      set_fwd(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
      tick();
    end
    idle();
    reset = 1'b1;
    tick();
    tick();

    // 2. Plain R-type
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 5'd0, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    #1;
    check("rtype_A", A, 32'd5);
    check("rtype_B", B, 32'd7);
    check("rtype_op", ALUOperation, 32'd3);
    check("rtype_valid", ex_valid, 32'd1);
    idle();
    tick();

    // 3. Forwarding priority on registered rs=$8
    set_id(1'b1, 5'd8, 5'd0, 5'd5, 32'h55, 32'd0, 32'd0, 5'd0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    set_fwd(1'b1, 5'd8, 32'h100, 1'b1, 5'd8, 32'h200);
    #1 check("fwd_exmem_first", A, 32'h100);
    set_fwd(1'b1, 5'd0, 32'h100, 1'b1, 5'd8, 32'h200);
    #1 check("fwd_memwb", A, 32'h200);
    set_fwd(1'b1, 5'd0, 32'h100, 1'b1, 5'd0, 32'h200);
    #1 check("fwd_zero_reg", A, 32'h55);
    tick();

    // 4. Load-use: lw $9 then add using $9 as rs
    idle();
    set_id(1'b1, 5'd1, 5'd9, 5'd9, 32'd0, 32'd0, 32'd4, 5'd0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd9, 5'd2, 5'd10, 32'hdead, 32'd3, 32'd0, 5'd0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 check("loaduse_stall", stall, 32'd1);
    tick();
    #1 check("loaduse_stall_drop", stall, 32'd0);
    check("loaduse_bubble", ex_valid, 32'd0);
    tick();
    idle();
    set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1234);
    #1 check("loaduse_A", A, 32'h1234);
    tick();

    // 5. Store with ALUSrc: B is the immediate, store data is forwarded $9
    idle();
    set_id(1'b1, 5'd1, 5'd9, 5'd0, 32'h20, 32'h77, 32'h10, 5'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    set_fwd(1'b1, 5'd9, 32'habc, 1'b0, 5'd0, 32'd0);
    #1 check("store_B", B, 32'h10);
    check("store_data", ex_StoreData, 32'habc);
    tick();
    set_id(1'b1, 5'd1, 5'd9, 5'd9, 32'd0, 32'd0, 32'd8, 5'd0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 5'd9, 5'd0, 32'h20, 32'h77, 32'h10, 5'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    #1 check("store_stall", stall, 32'd1);
    tick();
    tick();

    // 6. Flush, then flush together with a stall
    idle();
    set_id(1'b1, 5'd3, 5'd4, 5'd5, 32'd1, 32'd2, 32'd0, 5'd7, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    idle();
    #1 check("flush_valid", ex_valid, 32'd0);
    check("flush_rw", ex_RegWrite, 32'd0);
    tick();
    set_id(1'b1, 5'd1, 5'd9, 5'd9, 32'd0, 32'd0, 32'd4, 5'd0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd9, 5'd2, 5'd10, 32'hbeef, 32'd3, 32'd0, 5'd0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #1 check("flush_stall", stall, 32'd1);
    tick();
    flush = 1'b0;
    #1 check("flush_stall_bubble", ex_valid, 32'd0);
    tick();
    #1 check("after_bubble_valid", ex_valid, 32'd1);
    idle();
    tick();

    // Reset in the middle of a stall
    set_id(1'b1, 5'd1, 5'd9, 5'd9, 32'd0, 32'd0, 32'd4, 5'd0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd9, 5'd2, 5'd10, 32'hcafe, 32'd3, 32'd0, 5'd0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 check("rst_pre_stall", stall, 32'd1);
    reset = 1'b0;
    #1 check("rst_stall_drop", stall, 32'd0);
    check("rst_valid", ex_valid, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Random traffic over a few registers so hazards and forwarding collide
    for (int i = 0; i < 80; i++) begin
      set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 5'($urandom),
             4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      flush = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
